pingpong_bank_scheduler: RTL and testbench

- Sequences a pair of DEPTH x DATA_W single-clock RAM banks as a ping-pong (double) buffer.
- Accepts a producer stream (valid/ready) and writes one frame of DEPTH words into the current write bank. Meanwhile it drains the other, completed bank to a consumer stream (valid/ready).
- Owns all bank enables, addresses and write data, plus the write-bank/read-bank swap decisions.
- Sits between the data generator and the display-side reader in the beatmap pipeline, in the divided clock domain.

---
 rtl/pingpong_bank_scheduler_if.sv | 32 +++
 rtl/pingpong_bank_scheduler.sv | 175 +++++++++++++++++
 tb/tb_pingpong_bank_scheduler.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pingpong_bank_scheduler_if.sv
// Producer and consumer streams of the ping-pong bank scheduler.
// master = the producer/consumer side, slave = the scheduler.
interface pingpong_bank_scheduler_if #(
  parameter int unsigned DATA_W = 8
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/pingpong_bank_scheduler.sv
// Ping-pong scheduler for two DEPTH x DATA_W single-clock RAM banks.
// The writer fills bank wbank from the producer stream. The reader drains the
// completed bank rbank to the consumer stream. The RAMs have a read latency of
// one cycle, so the reader issues at most one read every other cycle.
module pingpong_bank_scheduler #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                      clk,
  input  logic                      resetn,

  pingpong_bank_scheduler_if.slave  bus,

  output logic                      bank0_we,
  output logic [ADDR_W-1:0]         bank0_waddr,
  output logic [DATA_W-1:0]         bank0_wdata,
  output logic                      bank1_we,
  output logic [ADDR_W-1:0]         bank1_waddr,
  output logic [DATA_W-1:0]         bank1_wdata,

  output logic                      bank0_re,
  output logic [ADDR_W-1:0]         bank0_raddr,
  input  logic [DATA_W-1:0]         bank0_rdata,
  output logic                      bank1_re,
  output logic [ADDR_W-1:0]         bank1_raddr,
  input  logic [DATA_W-1:0]         bank1_rdata,

  output logic [1:0]                bank_full,
  output logic                      wr_done,
  output logic                      rd_done
);

  // Counters are compared against the last frame address explicitly, so a
  // DEPTH smaller than 2**ADDR_W works without relying on natural wrap.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic              wbank_q,    wbank_d;
  logic              rbank_q,    rbank_d;
  logic [ADDR_W-1:0] waddr_q,    waddr_d;
  logic [ADDR_W-1:0] raddr_q,    raddr_d;
  logic [1:0]        full_q,     full_d;
  logic              rd_pend_q,  rd_pend_d;
  logic              src_q,      src_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              wr_done_q,  wr_done_d;
  logic              rd_done_q,  rd_done_d;

  logic              in_ready_c;
  logic              wr_fire_c;
  logic              wr_last_c;
  logic              rd_issue_c;
  logic              rd_last_c;

  // Handshake decisions; everything is held off while reset is asserted.
  always_comb begin
    in_ready_c = resetn && !full_q[wbank_q];
    wr_fire_c  = bus.in_valid && in_ready_c;
    wr_last_c  = (waddr_q == LAST_ADDR);
    rd_issue_c = resetn && full_q[rbank_q] && !rd_pend_q
                 && (!out_valid_q || bus.out_ready);
    rd_last_c  = (raddr_q == LAST_ADDR);
  end

  // Write port steering: only the current write bank sees an enable.
  always_comb begin
    bank0_we    = wr_fire_c && !wbank_q;
    bank1_we    = wr_fire_c &&  wbank_q;
    bank0_waddr = bank0_we ? waddr_q : '0;
    bank1_waddr = bank1_we ? waddr_q : '0;
    bank0_wdata = bank0_we ? bus.in_data : '0;
    bank1_wdata = bank1_we ? bus.in_data : '0;
  end

  // Read port steering: only the current read bank sees an enable.
  always_comb begin
    bank0_re    = rd_issue_c && !rbank_q;
    bank1_re    = rd_issue_c &&  rbank_q;
    bank0_raddr = bank0_re ? raddr_q : '0;
    bank1_raddr = bank1_re ? raddr_q : '0;
  end

  // Next-state: write counter, read counter, full flags and output stage.
  always_comb begin
    wbank_d     = wbank_q;
    rbank_d     = rbank_q;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    full_d      = full_q;
    rd_pend_d   = 1'b0;
    src_d       = src_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    wr_done_d   = 1'b0;
    rd_done_d   = 1'b0;

    if (wr_fire_c) begin
      if (wr_last_c) begin
        full_d[wbank_q] = 1'b1;
        waddr_d         = '0;
        wbank_d         = !wbank_q;
        wr_done_d       = 1'b1;
      end else begin
        waddr_d = waddr_q + ADDR_W'(1);
      end
    end

    // Writer only targets an EMPTY bank and reader only a FULL one, so the
    // two flag updates below never touch the same bit.
    if (rd_issue_c) begin
      rd_pend_d = 1'b1;
      src_d     = rbank_q;
      if (rd_last_c) begin
        full_d[rbank_q] = 1'b0;
        raddr_d         = '0;
        rbank_d         = !rbank_q;
        rd_done_d       = 1'b1;
      end else begin
        raddr_d = raddr_q + ADDR_W'(1);
      end
    end

    if (rd_pend_q) begin
      out_data_d  = src_q ? bank1_rdata : bank0_rdata;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      full_q      <= 2'b00;
      rd_pend_q   <= 1'b0;
      src_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wr_done_q   <= 1'b0;
      rd_done_q   <= 1'b0;
    end else begin
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      full_q      <= full_d;
      rd_pend_q   <= rd_pend_d;
      src_q       <= src_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      wr_done_q   <= wr_done_d;
      rd_done_q   <= rd_done_d;
    end
  end

  // Output drive.
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bank_full     = full_q;
  assign wr_done       = wr_done_q;
  assign rd_done       = rd_done_q;

  // Both banks full can only happen with the writer stalled on the read bank.
  a_full_same_bank: assert property (
    @(posedge clk) disable iff (!resetn)
      (full_q == 2'b11) |-> (wbank_q == rbank_q)
  );

endmodule

// File: tb/tb_pingpong_bank_scheduler.sv
// Directed and random bench for the ping-pong bank scheduler.
// Word k of the producer stream carries data k[7:0], so the expected
// consumer data is simply the running count of words taken.
module tb_pingpong_bank_scheduler;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pingpong_bank_scheduler_if #(.DATA_W(DATA_W)) bus ();

  logic              bank0_we, bank1_we, bank0_re, bank1_re;
  logic [ADDR_W-1:0] bank0_waddr, bank1_waddr, bank0_raddr, bank1_raddr;
  logic [DATA_W-1:0] bank0_wdata, bank1_wdata, bank0_rdata, bank1_rdata;
  logic [1:0]        bank_full;
  logic              wr_done, rd_done;

  pingpong_bank_scheduler #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .bank0_we    (bank0_we),
    .bank0_waddr (bank0_waddr),
    .bank0_wdata (bank0_wdata),
    .bank1_we    (bank1_we),
    .bank1_waddr (bank1_waddr),
    .bank1_wdata (bank1_wdata),
    .bank0_re    (bank0_re),
    .bank0_raddr (bank0_raddr),
    .bank0_rdata (bank0_rdata),
    .bank1_re    (bank1_re),
    .bank1_raddr (bank1_raddr),
    .bank1_rdata (bank1_rdata),
    .bank_full   (bank_full),
    .wr_done     (wr_done),
    .rd_done     (rd_done)
  );

  // Two RAM banks with one cycle of read latency.
  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];
  always @(posedge clk) begin
    if (bank0_we) mem0[bank0_waddr] <= bank0_wdata;
    if (bank1_we) mem1[bank1_waddr] <= bank1_wdata;
    if (bank0_re) bank0_rdata <= mem0[bank0_raddr];
    if (bank1_re) bank1_rdata <= mem1[bank1_raddr];
  end

  int checks = 0;
  int failures = 0;
  int wr_idx = 0;
  int rd_idx = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int viol = 0;
  int target = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at the falling edge: scoreboard the cycle, then cross the rising edge.
  task automatic commit();
    logic acc;
    logic xfer;
    acc  = resetn && bus.in_valid && bus.in_ready;
    xfer = resetn && bus.out_valid && bus.out_ready;
    if (xfer) begin
      check("out_order", 32'(bus.out_data), 32'(rd_idx[7:0]));
      rd_idx++;
    end
    if (bank0_we && bank0_re && bank0_waddr == bank0_raddr) viol++;
    if (bank1_we && bank1_re && bank1_waddr == bank1_raddr) viol++;
    if (bank_full == 2'b11 && bus.in_ready) viol++;
    if (wr_done) wr_pulses++;
    if (rd_done) rd_pulses++;
    @(posedge clk);
    #1;
    if (acc) wr_idx++;
    bus.in_data = DATA_W'(wr_idx);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    resetn        = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    @(negedge clk);
    check("rst_full", 32'(bank_full), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_done", 32'({wr_done, rd_done}), 0);
    check("rst_en", 32'({bank0_we, bank1_we, bank0_re, bank1_re}), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // Fill bank0 with words 0..31, consumer stalled
    bus.in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("a_we0", 32'(bank0_we), 1);
      check("a_waddr", 32'(bank0_waddr), 32'(i));
      check("a_wdata", 32'(bank0_wdata), 32'(i));
      check("a_we1", 32'(bank1_we), 0);
      commit();
    end

    // Fill bank1 with words 32..63
    for (int i = 32; i < 64; i++) begin
      @(negedge clk);
      if (i == 32) begin
        check("a_full", 32'(bank_full), 1);
        check("a_wr_done", 32'(wr_done), 1);
        check("a_in_ready", 32'(bus.in_ready), 1);
      end
      check("b_we1", 32'(bank1_we), 1);
      check("b_waddr", 32'(bank1_waddr), 32'(i - 32));
      check("b_we0", 32'(bank0_we), 0);
      commit();
    end

    // Word 64 is offered but both banks are full
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b_full", 32'(bank_full), 3);
      check("b_in_ready", 32'(bus.in_ready), 0);
      check("b_no_we", 32'({bank0_we, bank1_we}), 0);
      if (k == 0) check("b_wr_done", 32'(wr_done), 1);
      if (k == 3) begin
        check("b_prefetch_valid", 32'(bus.out_valid), 1);
        check("b_prefetch_data", 32'(bus.out_data), 0);
      end
      commit();
    end
    check("b_wr_pulses", 32'(wr_pulses), 2);

    // Drain both banks with the consumer always ready
    bus.out_ready = 1'b1;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      if (c % 2 == 0 && c <= 126) begin
        check("c_valid", 32'(bus.out_valid), 1);
        check("c_data", 32'(bus.out_data), 32'(c / 2));
      end else begin
        check("c_idle", 32'(bus.out_valid), 0);
      end
      if (c == 0) check("c_full0", 32'(bank_full), 3);
      if (c == 61) begin
        check("c_full61", 32'(bank_full), 2);
        check("c_rd_done0", 32'(rd_done), 1);
        check("c_held_we", 32'(bank0_we), 1);
        check("c_held_waddr", 32'(bank0_waddr), 0);
        check("c_held_wdata", 32'(bank0_wdata), 64);
      end
      if (c == 125) begin
        check("c_full125", 32'(bank_full), 0);
        check("c_rd_done1", 32'(rd_done), 1);
      end
      commit();
      if (wr_idx == 65) bus.in_valid = 1'b0;
    end
    check("c_rd_idx", 32'(rd_idx), 64);
    check("c_rd_pulses", 32'(rd_pulses), 2);

    // Complete bank0 (words 65..95) with the consumer stalled
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      check("d_we0", 32'(bank0_we), 1);
      check("d_waddr", 32'(bank0_waddr), 32'(i + 1));
      commit();
    end
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      commit();
    end

    // Take words 64 and 65, leaving 66 presented
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("d_valid", 32'(bus.out_valid), 1);
        check("d_data", 32'(bus.out_data), 64);
      end
      commit();
    end

    // Consumer stall while a word is presented
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("e_hold_valid", 32'(bus.out_valid), 1);
      check("e_hold_data", 32'(bus.out_data), 66);
      check("e_no_re", 32'({bank0_re, bank1_re}), 0);
      commit();
    end

    // Ten words into bank1, then a one-cycle reset mid-frame
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("e_we1", 32'(bank1_we), 1);
      check("e_waddr1", 32'(bank1_waddr), 32'(i));
      commit();
    end
    bus.in_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    commit();
    resetn = 1'b1;
    rd_idx = wr_idx;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("r_full", 32'(bank_full), 0);
        check("r_done", 32'({wr_done, rd_done}), 0);
        check("r_in_ready", 32'(bus.in_ready), 1);
      end
      check("r_out_valid", 32'(bus.out_valid), 0);
      check("r_no_re", 32'({bank0_re, bank1_re}), 0);
      commit();
    end
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("r_we0", 32'(bank0_we), 1);
    check("r_waddr0", 32'(bank0_waddr), 0);
    check("r_wdata0", 32'(bank0_wdata), 32'(rd_idx[7:0]));
    target = rd_idx + 1024;
    commit();

    // Random valid/ready for 32 full frames
    cyc = 0;
    while (rd_idx < target && cyc < 40000) begin
      bus.in_valid  = (wr_idx < target) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      commit();
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("f_drained", 32'(rd_idx), 32'(target));
    @(negedge clk);
    check("f_full", 32'(bank_full), 0);
    check("f_viol", 32'(viol), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
